// File: rtl/nap_timer_if.sv
// Command, preset and display bundle for the nap timer controller.
// master drives commands and presets; slave (the controller) drives the display and status.
interface nap_timer_if;
  logic       tick;
  logic       start;
  logic       pause;
  logic       cancel;
  logic [3:0] preset_min;
  logic [2:0] preset_st;
  logic [3:0] preset_so;
  logic [3:0] min;
  logic [2:0] st;
  logic [3:0] so;
  logic [1:0] state;
  logic       busy;
  logic       alarm;
  logic       done;

  modport master (
    output tick, start, pause, cancel, preset_min, preset_st, preset_so,
    input  min, st, so, state, busy, alarm, done
  );

  modport slave (
    input  tick, start, pause, cancel, preset_min, preset_st, preset_so,
    output min, st, so, state, busy, alarm, done
  );
endinterface

// File: rtl/nap_timer_ctrl.sv
// BCD m:ss countdown timer with run/pause/alarm control.
// The alarm phase lasts eight ticks before the timer drops back to idle.
module nap_timer_ctrl (
  input  logic         clock,
  input  logic         reset,
  nap_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    ALARM  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] min_q, min_d;
  logic [2:0] st_q, st_d;
  logic [3:0] so_q, so_d;
  logic [2:0] acnt_q, acnt_d;
  logic       busy_q, busy_d;
  logic       alarm_q, alarm_d;
  logic       done_q, done_d;

  logic [3:0] pmin, pso;
  logic [2:0] pst;
  logic       preset_nz;
  logic [3:0] dec_min, dec_so;
  logic [2:0] dec_st;
  logic       cnt_zero, dec_zero;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  function automatic logic [2:0] clamp_tens(input logic [2:0] v);
    return (v > 3'd5) ? 3'd5 : v;
  endfunction

  always_comb begin
    pmin      = clamp_bcd(bus.preset_min);
    pst       = clamp_tens(bus.preset_st);
    pso       = clamp_bcd(bus.preset_so);
    preset_nz = (pmin != 4'd0) || (pst != 3'd0) || (pso != 4'd0);
  end

  // One BCD countdown step with borrow chain so -> st -> min.
  always_comb begin
    dec_min = min_q;
    dec_st  = st_q;
    dec_so  = so_q;
    if (so_q != 4'd0) begin
      dec_so = so_q - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (st_q != 3'd0) begin
        dec_st = st_q - 3'd1;
      end else begin
        dec_st  = 3'd5;
        dec_min = min_q - 4'd1;
      end
    end
    cnt_zero = (min_q == 4'd0) && (st_q == 3'd0) && (so_q == 4'd0);
    dec_zero = (dec_min == 4'd0) && (dec_st == 3'd0) && (dec_so == 4'd0);
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    st_d    = st_q;
    so_d    = so_q;
    acnt_d  = acnt_q;
    done_d  = 1'b0;

    if (bus.cancel) begin
      state_d = IDLE;
      min_d   = 4'd0;
      st_d    = 3'd0;
      so_d    = 4'd0;
      acnt_d  = 3'd0;
    end else if (bus.start) begin
      if (preset_nz) begin
        state_d = RUN;
        min_d   = pmin;
        st_d    = pst;
        so_d    = pso;
        acnt_d  = 3'd0;
      end else if (state_q == RUN || state_q == PAUSED) begin
        // A zero reload while counting abandons the countdown.
        state_d = IDLE;
        min_d   = 4'd0;
        st_d    = 3'd0;
        so_d    = 4'd0;
        acnt_d  = 3'd0;
      end
    end else if (bus.pause) begin
      if (state_q == RUN)         state_d = PAUSED;
      else if (state_q == PAUSED) state_d = RUN;
    end else if (bus.tick) begin
      case (state_q)
        RUN: begin
          if (!cnt_zero) begin
            min_d = dec_min;
            st_d  = dec_st;
            so_d  = dec_so;
            if (dec_zero) begin
              state_d = ALARM;
              done_d  = 1'b1;
              acnt_d  = 3'd0;
            end
          end
        end
        ALARM: begin
          acnt_d = acnt_q + 3'd1;
          if (acnt_q == 3'd7) begin
            state_d = IDLE;
            acnt_d  = 3'd0;
          end
        end
        default: ;
      endcase
    end

    if (state_q != IDLE && state_q != RUN && state_q != PAUSED && state_q != ALARM) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end

    busy_d  = (state_d == RUN) || (state_d == PAUSED);
    alarm_d = (state_d == ALARM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      min_q   <= 4'd0;
      st_q    <= 3'd0;
      so_q    <= 4'd0;
      acnt_q  <= 3'd0;
      busy_q  <= 1'b0;
      alarm_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      st_q    <= st_d;
      so_q    <= so_d;
      acnt_q  <= acnt_d;
      busy_q  <= busy_d;
      alarm_q <= alarm_d;
      done_q  <= done_d;
    end
  end

  assign bus.min   = min_q;
  assign bus.st    = st_q;
  assign bus.so    = so_q;
  assign bus.state = state_q;
  assign bus.busy  = busy_q;
  assign bus.alarm = alarm_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_nap_timer_ctrl.sv
// Bench for nap_timer_ctrl: directed scenarios plus random commands against
// a model that keeps the remaining time as a plain count of seconds.
module tb_nap_timer_ctrl;

  logic clock;
  logic reset;
  nap_timer_if bus();

  nap_timer_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks;
  int n_fail;

  // Reference model: 0 idle, 1 run, 2 paused, 3 alarm
  int m_state;
  int m_total;
  int m_acnt;
  int m_done;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clear();
    m_state = 0;
    m_total = 0;
    m_acnt  = 0;
    m_done  = 0;
  endtask

  task automatic model_edge();
    int ptot;
    ptot = imin(int'(bus.preset_min), 9) * 60 + imin(int'(bus.preset_st), 5) * 10
         + imin(int'(bus.preset_so), 9);
    m_done = 0;
    if (bus.cancel) begin
      model_clear();
    end else if (bus.start) begin
      if (ptot != 0) begin
        m_state = 1;
        m_total = ptot;
        m_acnt  = 0;
      end else if (m_state == 1 || m_state == 2) begin
        model_clear();
      end
    end else if (bus.pause) begin
      if (m_state == 1)      m_state = 2;
      else if (m_state == 2) m_state = 1;
    end else if (bus.tick) begin
      if (m_state == 1 && m_total > 0) begin
        m_total--;
        if (m_total == 0) begin
          m_state = 3;
          m_done  = 1;
          m_acnt  = 0;
        end
      end else if (m_state == 3) begin
        m_acnt++;
        if (m_acnt == 8) begin
          m_state = 0;
          m_acnt  = 0;
        end
      end
    end
  endtask

  task automatic compare_model();
    check("state", int'(bus.state), m_state);
    check("min",   int'(bus.min),   m_total / 60);
    check("st",    int'(bus.st),    (m_total % 60) / 10);
    check("so",    int'(bus.so),    m_total % 10);
    check("busy",  int'(bus.busy),  (m_state == 1 || m_state == 2) ? 1 : 0);
    check("alarm", int'(bus.alarm), (m_state == 3) ? 1 : 0);
    check("done",  int'(bus.done),  m_done);
  endtask

  task automatic step(input logic t, input logic s, input logic p, input logic c,
                      input logic [3:0] pm, input logic [2:0] pst, input logic [3:0] pso);
    bus.tick       = t;
    bus.start      = s;
    bus.pause      = p;
    bus.cancel     = c;
    bus.preset_min = pm;
    bus.preset_st  = pst;
    bus.preset_so  = pso;
    @(posedge clock);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 4'd0);
  endtask

  task automatic tick_step();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 4'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, int'(bus.state), 0);
    check({tag, "_min"},   int'(bus.min),   0);
    check({tag, "_st"},    int'(bus.st),    0);
    check({tag, "_so"},    int'(bus.so),    0);
    check({tag, "_busy"},  int'(bus.busy),  0);
    check({tag, "_alarm"}, int'(bus.alarm), 0);
    check({tag, "_done"},  int'(bus.done),  0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("rst_now");
    model_clear();
    bus.tick  = 1'b1;
    bus.start = 1'b1;
    bus.preset_so = 4'd5;
    @(posedge clock);
    #1;
    check_reset_values("rst_hold");
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.preset_so = 4'd0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    reset          = 1'b0;
    bus.tick       = 1'b0;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.cancel     = 1'b0;
    bus.preset_min = 4'd0;
    bus.preset_st  = 3'd0;
    bus.preset_so  = 4'd0;
    #23;
    check_reset_values("por");
    reset = 1'b1;
    idle_step();

    // 0:1:0 then one tick -> 0:0:9 running
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd1, 4'd0);
    tick_step();
    check("s038_so", int'(bus.so), 9);
    check("s038_st", int'(bus.st), 0);
    check("s038_state", int'(bus.state), 1);

    // 1:0:0 then one tick -> 0:5:9
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 3'd0, 4'd0);
    tick_step();
    check("s039_min", int'(bus.min), 0);
    check("s039_st",  int'(bus.st),  5);
    check("s039_so",  int'(bus.so),  9);

    // 0:0:2 to alarm, done for one cycle, idle after eight alarm ticks
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 4'd2);
    tick_step();
    check("s040_done_early", int'(bus.done), 0);
    tick_step();
    check("s040_alarm_state", int'(bus.state), 3);
    check("s040_done", int'(bus.done), 1);
    idle_step();
    check("s040_done_once", int'(bus.done), 0);
    tick_step();
    check("s040_no_wrap", int'(bus.so), 0);
    for (int i = 0; i < 6; i++) tick_step();
    check("s040_still_alarm", int'(bus.state), 3);
    tick_step();
    check("s040_idle", int'(bus.state), 0);
    check("s040_alarm_off", int'(bus.alarm), 0);

    // pause and tick together, ticks held while paused
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd3, 4'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 4'd0);
    check("s041_paused", int'(bus.state), 2);
    check("s041_st", int'(bus.st), 3);
    for (int i = 0; i < 5; i++) tick_step();
    check("s041_hold_st", int'(bus.st), 3);
    check("s041_hold_so", int'(bus.so), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 4'd0);
    check("s041_resume", int'(bus.state), 1);

    // clamp and zero preset
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd12, 3'd7, 4'd15);
    check("s042_min", int'(bus.min), 9);
    check("s042_st",  int'(bus.st),  5);
    check("s042_so",  int'(bus.so),  9);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 4'd0);
    check("s042_zero_idle", int'(bus.state), 0);

    // cancel beats start and tick; reset mid-count
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 3'd2, 4'd2);
    tick_step();
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 3'd3, 4'd3);
    check("s043_cancel_state", int'(bus.state), 0);
    check("s043_cancel_so", int'(bus.so), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd4, 4'd4);
    tick_step();
    do_reset();
    idle_step();

    // reset during alarm must not leave a done pulse behind
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 4'd1);
    tick_step();
    tick_step();
    do_reset();
    idle_step();

    // randomized commands
    for (int n = 0; n < 4000; n++) begin
      logic t, s, p, c;
      logic [3:0] pm, pso;
      logic [2:0] pst;
      t = ($urandom % 100) < 55;
      s = ($urandom % 100) < 3;
      p = ($urandom % 100) < 4;
      c = ($urandom % 1000) < 8;
      if ($urandom % 2) begin
        pm  = 4'd0;
        pst = 3'($urandom % 2);
        pso = 4'($urandom % 16);
      end else begin
        pm  = 4'($urandom % 16);
        pst = 3'($urandom % 8);
        pso = 4'($urandom % 16);
      end
      step(t, s, p, c, pm, pst, pso);
      if (($urandom % 600) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nap_timer_ctrl.md
NAP_TIMER_CTRL -- requirements
Module: nap_timer_ctrl

Interface
REQ-001 The block SHALL have these ports: clock, input, 1 bit, system clock; all state changes on its rising edge.
REQ-002 The block SHALL have these ports: reset, input, 1 bit, asynchronous, active-low.
REQ-003 The block SHALL have these ports: tick, input, 1 bit, one-cycle 1 Hz enable pulse.
REQ-004 The block SHALL have these ports: start, input, 1 bit, load preset and begin countdown.
REQ-005 The block SHALL have these ports: pause, input, 1 bit, toggle between run and hold.
REQ-006 The block SHALL have these ports: cancel, input, 1 bit, abort to idle.
REQ-007 The block SHALL have these ports: preset_min, input, 4 bits, minutes, BCD 0-9.
REQ-008 The block SHALL have these ports: preset_st, input, 3 bits, seconds tens, 0-5.
REQ-009 The block SHALL have these ports: preset_so, input, 4 bits, seconds ones, BCD 0-9.
REQ-010 The block SHALL have these ports: min, output, 4 bits, current minutes digit.
REQ-011 The block SHALL have these ports: st, output, 3 bits, current seconds-tens digit.
REQ-012 The block SHALL have these ports: so, output, 4 bits, current seconds-ones digit.
REQ-013 The block SHALL have these ports: state, output, 2 bits, encoded as IDLE=0, RUN=1, PAUSED=2, ALARM=3.
REQ-014 The block SHALL have these ports: busy, output, 1 bit, high in RUN or PAUSED.
REQ-015 The block SHALL have these ports: alarm, output, 1 bit, high in ALARM.
REQ-016 The block SHALL have these ports: done, output, 1 bit, one-cycle pulse on the ALARM entry edge.
REQ-017 All outputs SHALL be registered.

Function
REQ-018 Command priority SHALL be cancel > start > pause > tick, evaluated each rising edge.
REQ-019 cancel SHALL force IDLE from any state, clear all digits to 0, and clear the alarm counter, next edge.
REQ-020 In IDLE, start SHALL load the preset digits and enter RUN on the same edge when the clamped preset is nonzero.
REQ-021 In IDLE, start with an all-zero clamped preset SHALL be ignored (remain IDLE).
REQ-022 Preset clamping SHALL be: preset_min > 9 loads 9; preset_so > 9 loads 9; preset_st > 5 loads 5.
REQ-023 In RUN, a tick SHALL perform one BCD countdown step: so = so-1 if so != 0, else so = 9 with a borrow into st.
REQ-024 A borrow into st SHALL give st = st-1 if st != 0, else st = 5 with a borrow into min.
REQ-025 A borrow into min SHALL give min = min-1.
REQ-026 A tick that makes all digits 0 SHALL enter ALARM on that edge, and done SHALL be 1 in the following cycle only.
REQ-027 A tick on a zero-valued counter SHALL NOT decrement; the block SHALL NOT wrap below 0:00.
REQ-028 Digit outputs SHALL reflect each step in the cycle after the tick edge; latency SHALL be 1 clock.
REQ-029 In RUN, pause SHALL enter PAUSED, and a tick in the same cycle SHALL be dropped.
REQ-030 In PAUSED, pause SHALL return to RUN; ticks SHALL be ignored and digits held.
REQ-031 start in RUN or PAUSED SHALL reload the preset and enter RUN, with zero-preset handling as in IDLE, except a zero preset goes to IDLE.
REQ-032 In ALARM, the block SHALL count ticks in a 3-bit counter and return to IDLE on the 8th tick, with alarm deasserting the cycle after.
REQ-033 In ALARM, start SHALL behave as in IDLE (snooze/restart); pause SHALL be ignored.
REQ-034 An unreachable or illegal state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-035 While reset=0, the block SHALL assert IDLE, min/st/so=0, busy=0, alarm=0, done=0, alarm counter=0, regardless of clock.
REQ-036 Deassertion SHALL take effect at the first rising clock edge after reset goes high.
REQ-037 Reset mid-RUN or mid-ALARM SHALL discard the count without emitting a done pulse.

Verification
REQ-038 Scenario: preset 0:01:0 (min=0, st=1, so=0), start, then one tick SHALL give 0:0:9 with state=RUN.
REQ-039 Scenario: preset 1:0:0, start, then one tick SHALL give 0:5:9 (double borrow).
REQ-040 Scenario: preset 0:0:2, start, 2 ticks SHALL give 0:0:0, state=ALARM, and done high exactly 1 cycle; 8 further ticks SHALL give IDLE.
REQ-041 Scenario: RUN at 0:3:0 with pause and tick in the same cycle SHALL give PAUSED at 0:3:0; 5 ticks SHALL leave it unchanged; pause SHALL give RUN.
REQ-042 Scenario: start with preset_min=12, st=7, so=15 SHALL load 9:5:9; start with all-zero preset SHALL leave IDLE.
REQ-043 Scenario: cancel, start and tick asserted together in RUN SHALL give IDLE with 0:0:0; reset low mid-count SHALL give the REQ-035 values immediately.
